// File: rtl/data_sync_hs.sv
// Destination-side bus synchronizer: the level request crosses through a flop
// chain, the bus is captured once the request is stable, and a 4-phase ack is returned.
module data_sync_hs #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_REQ,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic                 BUS_ACK
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACKED = 1'b1
  } state_t;

  state_t                 state_q;
  state_t                 next_state;
  logic [NUM_STAGES-1:0]  req_chain;
  logic                   req_s;
  logic [BUS_WIDTH-1:0]   sync_bus_q;
  logic [BUS_WIDTH-1:0]   sync_bus_d;
  logic                   pulse_q;
  logic                   pulse_d;
  logic                   ack_q;
  logic                   ack_d;

  // Plain flop chain with nothing between stages, so metastability can settle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      req_chain <= '0;
    end else begin
      req_chain <= {req_chain[NUM_STAGES-2:0], BUS_REQ};
    end
  end

  assign req_s = req_chain[NUM_STAGES-1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      sync_bus_q <= '0;
      pulse_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= next_state;
      sync_bus_q <= sync_bus_d;
      pulse_q    <= pulse_d;
      ack_q      <= ack_d;
    end
  end

  // The bus is only sampled on the IDLE->ACKED edge; the source holds it
  // stable until it sees BUS_ACK, so the capture is glitch-free.
  always_comb begin
    next_state = state_q;
    sync_bus_d = sync_bus_q;
    pulse_d    = 1'b0;
    ack_d      = ack_q;
    unique case (state_q)
      IDLE: begin
        ack_d = 1'b0;
        if (req_s) begin
          sync_bus_d = UNSYNC_BUS;
          pulse_d    = 1'b1;
          ack_d      = 1'b1;
          next_state = ACKED;
        end
      end
      ACKED: begin
        ack_d = 1'b1;
        if (!req_s) begin
          ack_d      = 1'b0;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign SYNC_BUS     = sync_bus_q;
  assign ENABLE_PULSE = pulse_q;
  assign BUS_ACK      = ack_q;

endmodule

// File: tb/tb_data_sync_hs.sv
// Self-checking bench for data_sync_hs (NUM_STAGES = 2, BUS_WIDTH = 8): a vector
// table for reset/single-transfer/ignore cases plus hand-written handshake sequences.
module tb_data_sync_hs;

  localparam int N = 2;
  localparam int W = 8;

  logic         CLK;
  logic         RST;
  logic [W-1:0] UNSYNC_BUS;
  logic         BUS_REQ;
  logic [W-1:0] SYNC_BUS;
  logic         ENABLE_PULSE;
  logic         BUS_ACK;

  int n_compared;
  int n_mismatched;
  int pulse_count;

  typedef struct {
    logic         rst;
    logic         req;
    logic [W-1:0] bus;
    logic [W-1:0] exp_sync;
    logic         exp_pulse;
    logic         exp_ack;
  } vec_t;

  vec_t vecs[14];

  data_sync_hs #(.NUM_STAGES(N), .BUS_WIDTH(W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .UNSYNC_BUS   (UNSYNC_BUS),
    .BUS_REQ      (BUS_REQ),
    .SYNC_BUS     (SYNC_BUS),
    .ENABLE_PULSE (ENABLE_PULSE),
    .BUS_ACK      (BUS_ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (ENABLE_PULSE) pulse_count++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic applyStimulus(input vec_t v);
    RST        = v.rst;
    BUS_REQ    = v.req;
    UNSYNC_BUS = v.bus;
    tick();
  endtask

  // Full 4-phase handshake carrying one word, with latency checks on both phases.
  task automatic doTransfer(input logic [W-1:0] data, input string tag);
    int cycles;
    bit found;
    UNSYNC_BUS = data;
    BUS_REQ    = 1'b1;
    cycles = 0;
    found  = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      cycles++;
      if (ENABLE_PULSE) found = 1;
    end
    checkOutput({tag, "_pulse_latency"}, cycles, N + 1);
    checkOutput({tag, "_sync_bus"}, SYNC_BUS, data);
    checkOutput({tag, "_ack_high"}, BUS_ACK, 1);
    tick();
    checkOutput({tag, "_pulse_one_cycle"}, ENABLE_PULSE, 0);
    BUS_REQ = 1'b0;
    cycles = 0;
    found  = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      cycles++;
      if (!BUS_ACK) found = 1;
    end
    checkOutput({tag, "_ack_fall_latency"}, cycles, N + 1);
  endtask

  initial begin
    int  base;
    int  cycles;
    bit  found;
    bit  ack_seen;

    n_compared   = 0;
    n_mismatched = 0;
    pulse_count  = 0;
    RST          = 1'b0;
    BUS_REQ      = 1'b0;
    UNSYNC_BUS   = '0;

    //        rst   req   bus    sync   pulse ack
    vecs[0]  = '{1'b0, 1'b1, 8'h77, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 8'hA5, 8'hA5, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 8'h3C, 8'hA5, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 8'h3C, 8'hA5, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 8'h3C, 8'hA5, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 8'h3C, 8'hA5, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'h5A, 8'hA5, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 8'h5A, 8'hA5, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_sync_bus", i), SYNC_BUS, vecs[i].exp_sync);
      checkOutput($sformatf("vec%0d_pulse", i), ENABLE_PULSE, vecs[i].exp_pulse);
      checkOutput($sformatf("vec%0d_ack", i), BUS_ACK, vecs[i].exp_ack);
    end
    checkOutput("table_pulse_total", pulse_count, 1);

    $display("[TB] back-to-back transfers");
    base = pulse_count;
    doTransfer(8'h01, "b2b0");
    doTransfer(8'h02, "b2b1");
    doTransfer(8'hFF, "b2b2");
    checkOutput("b2b_pulse_total", pulse_count - base, 3);

    $display("[TB] unsampled request glitch");
    base     = pulse_count;
    ack_seen = 0;
    BUS_REQ  = 1'b1;
    #3;
    BUS_REQ  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (BUS_ACK) ack_seen = 1;
    end
    checkOutput("glitch_no_pulse", pulse_count - base, 0);
    checkOutput("glitch_no_ack", ack_seen, 0);

    $display("[TB] request held high for 20 cycles");
    base       = pulse_count;
    UNSYNC_BUS = 8'h96;
    BUS_REQ    = 1'b1;
    repeat (20) tick();
    checkOutput("hold_one_pulse", pulse_count - base, 1);
    checkOutput("hold_sync_bus", SYNC_BUS, 8'h96);
    checkOutput("hold_ack", BUS_ACK, 1);
    BUS_REQ = 1'b0;
    repeat (N + 1) tick();
    checkOutput("hold_ack_release", BUS_ACK, 0);

    $display("[TB] reset while acked");
    UNSYNC_BUS = 8'hC3;
    BUS_REQ    = 1'b1;
    repeat (N + 2) tick();
    checkOutput("pre_reset_ack", BUS_ACK, 1);
    checkOutput("pre_reset_sync", SYNC_BUS, 8'hC3);
    RST = 1'b0;
    #1;
    checkOutput("async_reset_ack", BUS_ACK, 0);
    checkOutput("async_reset_pulse", ENABLE_PULSE, 0);
    checkOutput("async_reset_sync", SYNC_BUS, 8'h00);
    tick();
    tick();
    RST    = 1'b1;
    cycles = 0;
    found  = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      cycles++;
      if (ENABLE_PULSE) found = 1;
    end
    checkOutput("post_reset_latency", cycles, N + 1);
    checkOutput("post_reset_sync", SYNC_BUS, 8'hC3);
    checkOutput("post_reset_ack", BUS_ACK, 1);
    BUS_REQ = 1'b0;
    repeat (N + 1) tick();
    checkOutput("post_reset_ack_release", BUS_ACK, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
